// File: rtl/reg_fwd_ctrl.sv
// Decode-stage hazard/forwarding controller: tracks EX/WB destination registers and a
// multicycle R0 writer, selects operand forwarding for ports A/B and raises pipeline stalls.
module reg_fwd_ctrl #(
  parameter int unsigned REG_NUM_WIDTH     = 4,
  parameter int unsigned REG_FORWARD_WIDTH = 2,
  parameter int unsigned MC_LATENCY        = 4,
  parameter int unsigned MC_CNT_WIDTH      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic                         id_use_a,
  input  logic                         id_use_b,
  input  logic [REG_NUM_WIDTH-1:0]     id_rn_a,
  input  logic [REG_NUM_WIDTH-1:0]     id_rn_b,
  input  logic                         id_wr_en,
  input  logic [REG_NUM_WIDTH-1:0]     id_wr_rn,
  input  logic                         id_wr_r0,
  output logic [REG_FORWARD_WIDTH-1:0] fwd_a,
  output logic [REG_FORWARD_WIDTH-1:0] fwd_b,
  output logic                         stall
);

  localparam logic [REG_FORWARD_WIDTH-1:0] FWD_RF = REG_FORWARD_WIDTH'(0);
  localparam logic [REG_FORWARD_WIDTH-1:0] FWD_WB = REG_FORWARD_WIDTH'(1);
  localparam logic [REG_FORWARD_WIDTH-1:0] FWD_R0 = REG_FORWARD_WIDTH'(2);
  localparam logic [MC_CNT_WIDTH-1:0]      MC_LOAD = MC_CNT_WIDTH'(MC_LATENCY - 1);

  logic                     ex_valid_q, ex_valid_d;
  logic                     ex_wr_en_q, ex_wr_en_d;
  logic [REG_NUM_WIDTH-1:0] ex_rn_q, ex_rn_d;
  logic                     ex_wr_r0_q, ex_wr_r0_d;
  logic                     wb_valid_q, wb_valid_d;
  logic                     wb_wr_en_q, wb_wr_en_d;
  logic [REG_NUM_WIDTH-1:0] wb_rn_q, wb_rn_d;
  logic [MC_CNT_WIDTH-1:0]  mc_cnt_q, mc_cnt_d;

  logic                         r0_busy;
  logic                         hz_a, hz_b, stall_raw, advance;
  logic [REG_FORWARD_WIDTH-1:0] fwd_a_raw, fwd_b_raw;

  // Returns {hazard, fwd_select} for one source operand.
  function automatic logic [REG_FORWARD_WIDTH:0] src_decode(
    input logic                     used,
    input logic [REG_NUM_WIDTH-1:0] rn,
    input logic                     busy,
    input logic                     ex_hit_en,
    input logic [REG_NUM_WIDTH-1:0] ex_rn,
    input logic                     wb_hit_en,
    input logic [REG_NUM_WIDTH-1:0] wb_rn
  );
    logic [REG_FORWARD_WIDTH:0] r;
    r = {1'b0, FWD_RF};
    if (used) begin
      if (rn == '0)                     r = {busy, FWD_R0};
      else if (ex_hit_en && ex_rn == rn) r = {1'b1, FWD_RF};
      else if (wb_hit_en && wb_rn == rn) r = {1'b0, FWD_WB};
    end
    return r;
  endfunction

  always_comb begin
    r0_busy = (ex_valid_q & ex_wr_r0_q) | (mc_cnt_q != '0);
    {hz_a, fwd_a_raw} = src_decode(id_valid & id_use_a, id_rn_a, r0_busy,
                                   ex_valid_q & ex_wr_en_q, ex_rn_q,
                                   wb_valid_q & wb_wr_en_q, wb_rn_q);
    {hz_b, fwd_b_raw} = src_decode(id_valid & id_use_b, id_rn_b, r0_busy,
                                   ex_valid_q & ex_wr_en_q, ex_rn_q,
                                   wb_valid_q & wb_wr_en_q, wb_rn_q);
    stall_raw = hz_a | hz_b | (id_valid & id_wr_r0 & r0_busy);
    advance   = id_valid & ~stall_raw;
  end

  always_comb begin
    wb_valid_d = ex_valid_q;
    wb_wr_en_d = ex_wr_en_q;
    wb_rn_d    = ex_rn_q;
    ex_valid_d = advance;
    ex_wr_en_d = advance & id_wr_en;
    ex_rn_d    = advance ? id_wr_rn : '0;
    ex_wr_r0_d = advance & id_wr_r0;
    mc_cnt_d   = mc_cnt_q;
    if (advance && id_wr_r0)  mc_cnt_d = MC_LOAD;
    else if (mc_cnt_q != '0)  mc_cnt_d = mc_cnt_q - MC_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_wr_en_q <= 1'b0;
      ex_rn_q    <= '0;
      ex_wr_r0_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_wr_en_q <= 1'b0;
      wb_rn_q    <= '0;
      mc_cnt_q   <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_wr_en_q <= ex_wr_en_d;
      ex_rn_q    <= ex_rn_d;
      ex_wr_r0_q <= ex_wr_r0_d;
      wb_valid_q <= wb_valid_d;
      wb_wr_en_q <= wb_wr_en_d;
      wb_rn_q    <= wb_rn_d;
      mc_cnt_q   <= mc_cnt_d;
    end
  end

  // Outputs are gated by reset so an R0 reader in ID cannot show 10 while reset is held.
  always_comb begin
    fwd_a = rst ? fwd_a_raw : '0;
    fwd_b = rst ? fwd_b_raw : '0;
    stall = rst & stall_raw;
  end

endmodule
